imm_prefix_extender: RTL and testbench
======================================

# imm_prefix_extender

Parametrised, sequential successor to the SIC-4 immediate sign extender. Accumulates one or more narrow immediate chunks from prefix instructions into a single operand. Zero- or sign-extends the result to datapath width and hands it to the execute stage over a valid/ready handshake. Sits between decode and the ALU operand mux.

## Interface
- CHUNK_W, 2: bits per immediate chunk; must be ≥1.
- OUT_W, 8: operand width; OUT_W % CHUNK_W must be 0 (elaboration error otherwise).
- MAX_CHUNKS, OUT_W/CHUNK_W: derived localparam, not overridable.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  chunk present.
- in_ready  out  1  block can accept a chunk this cycle.
- in_chunk  in  CHUNK_W  immediate chunk, most-significant chunk first.
- in_last  in  1  this chunk completes the immediate.
- in_mode  in  1  0 = zero-extend, 1 = sign-extend; sampled only with the last chunk.
- out_valid  out  1  extended operand available.
- out_ready  in  1  consumer takes the operand.
- out  out  OUT_W  extended operand.
- out_ovf  out  1  more than MAX_CHUNKS chunks went into this operand; high bits were dropped.

## Operation
- Accept: a chunk is accepted when in_valid && in_ready.
- in_ready = !RST && !(out_valid && !out_ready).
- Accumulator: acc ← (acc << CHUNK_W) | in_chunk, truncated to OUT_W. cnt ← min(cnt+1, MAX_CHUNKS). ovf_sticky is set if cnt == MAX_CHUNKS before the accept.
- On an accepted chunk with in_last:
  - Form n = cnt_next·CHUNK_W valid bits.
  - Extend: if in_mode = 1 and n < OUT_W, bits [OUT_W-1:n] are copied from bit n-1. Otherwise they are zero. If n = OUT_W, acc is passed through unchanged.
  - Result goes to the out register. out_ovf ← ovf_sticky_next. out_valid ← 1.
  - acc, cnt and ovf_sticky clear in the same edge.
- States:
  - IDLE: cnt = 0, out_valid = 0.
  - ACCUM: cnt > 0, no last chunk yet.
  - HOLD: out_valid = 1.
  - Accepting chunks while in HOLD with out_ready = 1 is legal, so the state is the pair {cnt, out_valid} rather than a one-hot FSM.
- Output handshake:
  - out_valid && out_ready at an edge, with no new last chunk accepted → out_valid ← 0.
  - Simultaneous pop and new last chunk → out and out_ovf replaced by the new result; out_valid stays 1.
- Backpressure: while out_valid && !out_ready, in_ready = 0. The accumulator and a partially built immediate are frozen. out, out_ovf and out_valid are held stable.
- Reset, including mid-accumulation or during HOLD: acc = 0, cnt = 0, ovf_sticky = 0, out = 0, out_ovf = 0, out_valid = 0. No residue from a partial immediate survives.
- in_mode on non-last chunks is ignored.

## Timing
- Latency: last chunk accepted at edge N → out_valid = 1 and out valid from edge N until popped.
- Throughput: one single-chunk immediate per cycle with out_ready held at 1. A k-chunk immediate takes k accepted cycles.
- out and out_ovf are registered only; no combinational path from in_* to out*.
- in_ready has a combinational path from out_ready only.
- Reset values: out = 0, out_valid = 0, out_ovf = 0, in_ready = 0 while RST = 1 and 1 on the first cycle after.

## Structure
- Shared package sic4_pkg holds:
  - EXT_ZERO = 1'b0 and EXT_SIGN = 1'b1.
  - Default CHUNK_W and OUT_W.
  - Width-check function used in the elaboration assertion.
- Sub-module var_extender: purely combinational, parametrised on OUT_W.
  - Inputs: acc, n_bits, mode. Output: extended value.
  - Replaces the old fixed 2→8 extender and is reused by the branch-offset path.
- Top level holds acc, cnt, ovf_sticky, the output register and the handshake logic.

## Test plan
All scenarios use CHUNK_W = 2, OUT_W = 8.
- Single chunks with in_last, out_ready = 1:
  - 2'b10 sign → out = 8'hFE.
  - 2'b10 zero → 8'h02.
  - 2'b01 sign → 8'h01.
  - 2'b11 sign → 8'hFF.
  - Each appears exactly one edge after its accept.
- Multi-chunk:
  - 01, 10, 11 (last, sign) → out = 8'h1B, out_ovf = 0.
  - 11, 00 (last, sign) → 8'hFC.
  - Same 11, 00 with zero mode → 8'h0C.
- Overflow: 01, 00, 00, 00, 11 (last) → out = 8'h03, out_ovf = 1. The following single 01 → 8'h01, out_ovf = 0.
- Backpressure:
  - out_ready = 0 after a result → in_ready = 0 and out holds for 5 cycles while in_valid presents chunk 10.
  - Raise out_ready → old value popped and 10 accepted in the same edge; new out = 8'hFE on the next edge.
- Reset mid-operation:
  - Chunks 11, 11 then RST for one cycle → all outputs 0.
  - Then 01 (last, sign) → 8'h01, with no residue.
- Back-to-back: 8 consecutive single-chunk immediates with out_ready = 1 → 8 results on 8 consecutive edges, out_valid never drops.

Source files
------------

// File: rtl/sic4_pkg.sv
// Shared definitions for the SIC-4 immediate path: extension modes, default
// widths and the chunk/operand width legality check.
package sic4_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam int DEF_CHUNK_W = 2;
  localparam int DEF_OUT_W   = 8;

  // An operand must be built from a whole number of chunks, at least one of them.
  function automatic bit widths_ok(input int chunk_w, input int out_w);
    return (chunk_w >= 1) && (out_w >= chunk_w) && ((out_w % chunk_w) == 0);
  endfunction

endpackage

// File: rtl/var_extender.sv
// Combinational extender: keeps the low n_bits of acc and fills the bits above
// with either zero or a copy of bit n_bits-1.
module var_extender
  import sic4_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W,
  parameter int NB_W  = $clog2(OUT_W + 1)
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [NB_W-1:0]  n_bits,
  input  logic             mode,
  output logic [OUT_W-1:0] ext
);

  logic sign;

  // The sign bit is found by position search so n_bits == 0 never indexes out of range.
  always_comb begin
    sign = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      if (n_bits == NB_W'(i + 1)) sign = acc[i];
    end
    ext = acc;
    for (int i = 0; i < OUT_W; i++) begin
      if (NB_W'(i) >= n_bits) ext[i] = (mode == EXT_SIGN) & sign;
    end
  end

endmodule

// File: rtl/imm_prefix_extender.sv
// Accumulates prefix-instruction immediate chunks (MS chunk first) into one
// operand, extends it and presents it to execute over a valid/ready handshake.
module imm_prefix_extender
  import sic4_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_chunk,
  input  logic               in_last,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out,
  output logic               out_ovf
);

  localparam int MAX_CHUNKS = OUT_W / CHUNK_W;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1);
  localparam int NB_W       = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHUNKS);

  if (!widths_ok(CHUNK_W, OUT_W)) begin : g_bad_widths
    $error("imm_prefix_extender: OUT_W must be a non-zero multiple of CHUNK_W");
  end

  logic [OUT_W-1:0]         acc;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_sticky;

  logic                     accept;
  logic                     pop;
  logic [OUT_W+CHUNK_W-1:0] acc_wide;
  logic [OUT_W-1:0]         acc_next;
  logic [CNT_W-1:0]         cnt_next;
  logic                     ovf_next;
  logic [NB_W-1:0]          n_bits;
  logic [OUT_W-1:0]         ext_val;

  // A held, unconsumed result blocks new chunks so a partial immediate stays frozen.
  assign in_ready = !rst && !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    acc_wide = {acc, in_chunk};
    acc_next = acc_wide[OUT_W-1:0];
    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    ovf_next = ovf_sticky | (cnt == CNT_MAX);
    n_bits   = NB_W'(int'(cnt_next) * CHUNK_W);
  end

  var_extender #(
    .OUT_W (OUT_W),
    .NB_W  (NB_W)
  ) u_ext (
    .acc    (acc_next),
    .n_bits (n_bits),
    .mode   (in_mode),
    .ext    (ext_val)
  );

  // A last chunk both loads the result and wipes the accumulator, so a pop in the
  // same edge simply sees out_valid stay high with the new operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out        <= '0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (accept && in_last) begin
      out        <= ext_val;
      out_ovf    <= ovf_next;
      out_valid  <= 1'b1;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (accept) begin
        acc        <= acc_next;
        cnt        <= cnt_next;
        ovf_sticky <= ovf_next;
      end
      if (pop) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_prefix_extender.sv
// Directed bench for imm_prefix_extender (CHUNK_W=2, OUT_W=8) with a queue-based
// reference model compared every cycle plus literal result checks.
module tb_imm_prefix_extender;

  localparam int CW   = 2;
  localparam int OW   = 8;
  localparam int MAXC = OW / CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_chunk = '0;
  logic          in_last = 1'b0;
  logic          in_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out;
  logic          out_ovf;

  int errors = 0;
  int checks = 0;

  imm_prefix_extender #(.CHUNK_W(CW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chunk  (in_chunk),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value from the chunk list: the newest MAXC chunks as a number,
  // reinterpreted as a signed n-bit quantity when sign mode is requested.
  function automatic logic [OW-1:0] model_value(input int chunks[$], input logic mode);
    int k, used, n, v;
    k    = chunks.size();
    used = (k > MAXC) ? MAXC : k;
    n    = used * CW;
    v    = 0;
    for (int i = k - used; i < k; i++) v = v * (1 << CW) + chunks[i];
    if (mode && n < OW && ((v >> (n - 1)) & 1) == 1) v = v - (1 << n);
    return OW'(v);
  endfunction

  int            m_q[$];
  logic [OW-1:0] m_out = '0;
  logic          m_ovf = 1'b0;
  logic          m_valid = 1'b0;

  always @(posedge clk) begin
    bit rdy, take;
    if (rst) begin
      m_q.delete();
      m_out   = '0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      rdy  = !(m_valid && !out_ready);
      take = in_valid && rdy;
      if (take) m_q.push_back(int'(in_chunk));
      if (take && in_last) begin
        m_out   = model_value(m_q, in_mode);
        m_ovf   = (m_q.size() > MAXC);
        m_valid = 1'b1;
        m_q.delete();
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("mon_in_ready",  32'(in_ready),  32'(!rst && !(m_valid && !out_ready)));
    check("mon_out_valid", 32'(out_valid), 32'(m_valid));
    check("mon_out",       32'(out),       32'(m_out));
    check("mon_out_ovf",   32'(out_ovf),   32'(m_ovf));
  end

  // Presents one chunk for exactly one edge; returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [CW-1:0] chunk, input logic last, input logic mode);
    in_valid = 1'b1;
    in_chunk = chunk;
    in_last  = last;
    in_mode  = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [OW-1:0] exp_out, input logic exp_ovf);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_out"},   32'(out),       32'(exp_out));
    check({name, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
    check({name, "_model"}, 32'({m_ovf, m_out}), 32'({exp_ovf, exp_out}));
  endtask

  initial begin
    logic [CW-1:0] c;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",       32'(out),       32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(2'b10, 1'b1, 1'b1); checkOutput("s10_sign", 8'hFE, 1'b0);
    applyStimulus(2'b10, 1'b1, 1'b0); checkOutput("s10_zero", 8'h02, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b1); checkOutput("s01_sign", 8'h01, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1); checkOutput("s11_sign", 8'hFF, 1'b0);

    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1); checkOutput("m3_sign", 8'h1B, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b1); checkOutput("m2_sign", 8'hFC, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b1, 1'b0); checkOutput("m2_zero", 8'h0C, 1'b0);

    applyStimulus(2'b01, 1'b0, 1'b0);
    repeat (3) applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1); checkOutput("ovf5", 8'h03, 1'b1);
    applyStimulus(2'b01, 1'b1, 1'b1); checkOutput("after_ovf", 8'h01, 1'b0);

    // Backpressure: result 01 stays put while chunk 10 waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_chunk  = 2'b10;
    in_last   = 1'b1;
    in_mode   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold", 8'h01, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("bp_new", 8'hFE, 1'b0);

    applyStimulus(2'b11, 1'b0, 1'b1);
    applyStimulus(2'b11, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out",       32'(out),       32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    applyStimulus(2'b01, 1'b1, 1'b1); checkOutput("no_residue", 8'h01, 1'b0);

    // Eight single-chunk immediates on consecutive edges; the monitor sees out_valid every cycle.
    for (int i = 0; i < 8; i++) begin
      c = CW'(i);
      in_valid = 1'b1;
      in_chunk = c;
      in_last  = 1'b1;
      in_mode  = i[2];
      @(posedge clk);
      #1;
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_out", 32'(out), 32'(model_value('{int'(c)}, i[2])));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("b2b_last", 8'hFF, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
